mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/load_formatter.sv | 27 ++
 rtl/mem_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared access-size and writeback-select encodings plus MEM FSM state type
package riscv_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_e;

  // 2'b11 aliases word, so the upper bit alone identifies a word access
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - selects the addressed byte/half lane of a load word and extends it
module load_formatter
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = 8'(rdata >> {addr_lo, 3'b000});
  assign half_lane = 16'(rdata >> {addr_lo, 3'b000});

  always_comb begin
    data = rdata;
    if (size == SIZE_BYTE) begin
      data = {{24{sgn & byte_lane[7]}}, byte_lane};
    end else if (size == SIZE_HALF) begin
      data = {{16{sgn & half_lane[15]}}, half_lane};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: data-memory handshake, load formatting, MEM/WB register.
// Optional misaligned-access trap enabled by MEM_MISALIGN_TRAP_EN.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            mem_pc,
  input  logic [31:0]            mem_alu_result,
  input  logic [31:0]            mem_rs2_val_for_store,
  input  logic [31:0]            mem_wb_candidate,
  input  logic [31:0]            mem_csr_data,
  input  logic [4:0]             mem_rd_addr,
  input  logic [1:0]             mem_wb_sel,
  input  logic [1:0]             mem_load_size,
  input  logic [1:0]             mem_store_size,
  input  logic                   mem_reg_write,
  input  logic                   mem_mem_read,
  input  logic                   mem_mem_write,
  input  logic                   mem_load_signed,
  input  logic                   mem_csr_hit,
  output logic                   dmem_req_valid,
  input  logic                   dmem_req_ready,
  output logic [31:0]            dmem_addr,
  output logic                   dmem_we,
  output logic [31:0]            dmem_wdata,
  output logic [3:0]             dmem_wstrb,
  input  logic                   dmem_rsp_valid,
  input  logic [31:0]            dmem_rdata,
  output logic                   mem_stall,
  output logic [31:0]            wb_pc,
  output logic [31:0]            wb_data,
  output logic [4:0]             wb_rd_addr,
  output logic                   wb_reg_write,
  output logic [STALL_CNT_W-1:0] stall_cycles
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                   mem_misalign
`endif
);

  mem_state_e  state, state_next;
  logic        is_load, is_store, trap, wb_write_next;
  logic [31:0] load_data, wb_value;

  // A load wins when read and write are both set
  assign is_load  = mem_mem_read;
  assign is_store = mem_mem_write & ~mem_mem_read;

`ifdef MEM_MISALIGN_TRAP_EN
  logic [1:0] acc_size;
  logic       misaligned;
  assign acc_size   = is_load ? mem_load_size : mem_store_size;
  assign misaligned = (acc_size == SIZE_HALF && mem_alu_result[0]) ||
                      (is_word(acc_size) && mem_alu_result[1:0] != 2'b00);
  assign trap       = (state == IDLE) & (is_load | is_store) & misaligned;
`else
  assign trap       = 1'b0;
`endif

  always_comb begin
    state_next     = state;
    dmem_req_valid = 1'b0;
    mem_stall      = 1'b0;
    if (!rst) begin
      case (state)
        IDLE, REQ: begin
          if (state == REQ || ((is_load | is_store) && !trap)) begin
            dmem_req_valid = 1'b1;
            if (!dmem_req_ready) begin
              state_next = REQ;
              mem_stall  = 1'b1;
            end else if (is_load) begin
              state_next = WAIT;
              mem_stall  = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end
        end
        WAIT: begin
          if (dmem_rsp_valid) state_next = IDLE;
          else                mem_stall  = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign dmem_addr = mem_alu_result;
  assign dmem_we   = is_store;

  always_comb begin
    dmem_wdata = mem_rs2_val_for_store;
    dmem_wstrb = 4'b1111;
    if (mem_store_size == SIZE_BYTE) begin
      dmem_wdata = {4{mem_rs2_val_for_store[7:0]}};
      dmem_wstrb = 4'b0001 << mem_alu_result[1:0];
    end else if (mem_store_size == SIZE_HALF) begin
      dmem_wdata = {2{mem_rs2_val_for_store[15:0]}};
      dmem_wstrb = 4'b0011 << {mem_alu_result[1], 1'b0};
    end
  end

  load_formatter u_load_formatter (
    .rdata   (dmem_rdata),
    .addr_lo (mem_alu_result[1:0]),
    .size    (mem_load_size),
    .sgn     (mem_load_signed),
    .data    (load_data)
  );

  assign wb_value      = mem_csr_hit               ? mem_csr_data :
                         (mem_wb_sel == WB_SEL_MEM) ? load_data    : mem_wb_candidate;
  assign wb_write_next = mem_reg_write & (mem_rd_addr != 5'd0) & ~is_store & ~trap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wb_pc        <= '0;
      wb_data      <= '0;
      wb_rd_addr   <= '0;
      wb_reg_write <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state   <= state_next;
      wb_pc   <= mem_pc;
      wb_data <= wb_value;
      if (mem_stall) begin
        wb_rd_addr   <= '0;
        wb_reg_write <= 1'b0;
      end else begin
        wb_rd_addr   <= mem_rd_addr;
        wb_reg_write <= wb_write_next;
      end
      if (mem_stall && stall_cycles != '1) stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) mem_misalign <= 1'b0;
    else     mem_misalign <= trap;
  end
`endif

endmodule
